// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the RV32I inter-stage pipeline registers:
// control-bundle bit positions, the NOP encoding and per-stage data widths.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 6;

  typedef enum int unsigned {
    CTRL_ULA         = 0,
    CTRL_MUX_RES_ULA = 1,
    CTRL_MEM_RD      = 2,
    CTRL_MEM_WR      = 3,
    CTRL_REG_WR      = 4,
    CTRL_MUX_REG_WR  = 5
  } ctrl_bit_e;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  localparam int unsigned DATA_W_IF_ID  = 64;
  localparam int unsigned DATA_W_ID_EX  = 144;
  localparam int unsigned DATA_W_EX_MEM = 101;
  localparam int unsigned DATA_W_MEM_WB = 69;

  function automatic logic is_nop(input logic [CTRL_W_DEF-1:0] c);
    return c == CTRL_NOP;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat bus carrying a control bundle and a data bundle.
interface pipe_stage_reg_if #(
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned DATA_W = 144
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, ctrl, data, input ready);
  modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_stage_reg_entry.sv
// One held beat: enable-loaded ctrl/data/valid register with a squash input
// that clears valid and ctrl but leaves the data bits alone.
module pipe_entry #(
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned DATA_W = 144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush, optional skid entry
// and a saturating bubble counter for the downstream stage.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_ID_EX,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned SKID   = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  pipe_stage_reg_if.slave     up,
  pipe_stage_reg_if.master    dn,
  output logic [CNT_W-1:0]    bubble_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              main_en;
  logic              main_d_valid;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = up.valid & up.ready;
  assign out_xfer = main_valid & dn.ready;

  assign dn.valid = main_valid;
  assign dn.data  = main_data;
  assign dn.ctrl  = main_valid ? main_ctrl : CTRL_W'(CTRL_NOP);

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .en      (main_en),
    .d_valid (main_d_valid),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_data  (main_data)
  );

  if (SKID == 0) begin : g_single
    assign up.ready = dn.ready | ~main_valid;

    always_comb begin
      main_en      = in_xfer | out_xfer;
      main_d_valid = in_xfer;
      main_d_ctrl  = up.ctrl;
      main_d_data  = up.data;
    end
  end else begin : g_skid
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_en;
    logic              skid_d_valid;

    // in_ready comes straight from a flop, so no combinational path from out_ready.
    assign up.ready = ~skid_valid;

    always_comb begin
      main_en      = 1'b0;
      main_d_valid = in_xfer;
      main_d_ctrl  = up.ctrl;
      main_d_data  = up.data;
      skid_en      = 1'b0;
      skid_d_valid = 1'b0;
      if (out_xfer) begin
        main_en = 1'b1;
        if (skid_valid) begin
          main_d_valid = 1'b1;
          main_d_ctrl  = skid_ctrl;
          main_d_data  = skid_data;
          skid_en      = 1'b1;
        end
      end else if (in_xfer) begin
        if (!main_valid) begin
          main_en = 1'b1;
        end else begin
          skid_en      = 1'b1;
          skid_d_valid = 1'b1;
        end
      end
    end

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .en      (skid_en),
      .d_valid (skid_d_valid),
      .d_ctrl  (up.ctrl),
      .d_data  (up.data),
      .q_valid (skid_valid),
      .q_ctrl  (skid_ctrl),
      .q_data  (skid_data)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (dn.ready && !main_valid && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (SKID=0, SKID=1,
// SKID=0 with a 2-bit bubble counter) driven per-instance.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   flush;
  logic [2:0]   iv;
  logic [2:0]   ordy;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [5:0]   ic   [3];
  logic [5:0]   oc   [3];
  logic [143:0] idat [3];
  logic [143:0] od   [3];
  logic [15:0]  bc   [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int unsigned CW = (g == 2) ? 2 : 16;
    pipe_stage_reg_if #(.CTRL_W(6), .DATA_W(144)) up ();
    pipe_stage_reg_if #(.CTRL_W(6), .DATA_W(144)) dn ();
    logic [CW-1:0] bcl;

    assign up.valid = iv[g];
    assign up.ctrl  = ic[g];
    assign up.data  = idat[g];
    assign dn.ready = ordy[g];
    assign ir[g]    = up.ready;
    assign ov[g]    = dn.valid;
    assign oc[g]    = dn.ctrl;
    assign od[g]    = dn.data;
    assign bc[g]    = 16'(bcl);

    pipe_stage_reg #(
      .DATA_W (144),
      .CTRL_W (6),
      .SKID   ((g == 1) ? 1 : 0),
      .CNT_W  (CW)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush[g]),
      .up         (up),
      .dn         (dn),
      .bubble_cnt (bcl)
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = '0; iv = '0; ordy = '1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // load a beat and stall so reset has something to drop; flush asserted alongside
    rst = 1'b0; flush = '0; ordy = '0; iv = '1;
    for (int d = 0; d < 3; d++) begin ic[d] = 6'h2A; idat[d] = 144'h55; end
    cyc();
    rst = 1'b1; flush = '1;
    cyc();
    for (int d = 0; d < 3; d++) begin
      if (ov[d] !== 1'b0) begin $display("FAIL reset_valid dut%0d got %b want 0", d, ov[d]); n_err++; end
      n_cmp++;
      if (oc[d] !== 6'h0) begin $display("FAIL reset_ctrl dut%0d got %h want 00", d, oc[d]); n_err++; end
      n_cmp++;
      if (od[d] !== 144'h0) begin $display("FAIL reset_data dut%0d got %h want 0", d, od[d]); n_err++; end
      n_cmp++;
      if (bc[d] !== 16'h0) begin $display("FAIL reset_bubble dut%0d got %0d want 0", d, bc[d]); n_err++; end
      n_cmp++;
      if (ir[d] !== 1'b1) begin $display("FAIL reset_ready dut%0d got %b want 1", d, ir[d]); n_err++; end
      n_cmp++;
    end
    rst = 1'b0; flush = '0; iv = '0; ordy = '1;
  endtask

  task automatic test_stream(input int d);
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      iv[d] = 1'b1; ic[d] = 6'(i); idat[d] = 144'(i);
      #1;
      if (ir[d] !== 1'b1) begin $display("FAIL stream_ready dut%0d beat%0d got %b want 1", d, i, ir[d]); n_err++; end
      n_cmp++;
      cyc();
      if (ov[d] !== 1'b1 || od[d] !== 144'(i)) begin
        $display("FAIL stream_data dut%0d beat%0d got v=%b d=%0h want v=1 d=%0h", d, i, ov[d], od[d], i);
        n_err++;
      end
      n_cmp++;
    end
    iv[d] = 1'b0;
    cyc();
    if (ov[d] !== 1'b0) begin $display("FAIL stream_drain dut%0d got %b want 0", d, ov[d]); n_err++; end
    n_cmp++;
  endtask

  task automatic test_stall_skid();
    do_reset();
    ordy[1] = 1'b0; iv[1] = 1'b1; ic[1] = 6'h0A; idat[1] = 144'hA;
    cyc();
    if (ov[1] !== 1'b1 || od[1] !== 144'hA || ir[1] !== 1'b1) begin
      $display("FAIL skid_a_main got v=%b d=%0h r=%b want v=1 d=a r=1", ov[1], od[1], ir[1]); n_err++;
    end
    n_cmp++;
    ic[1] = 6'h0B; idat[1] = 144'hB;
    cyc();
    if (od[1] !== 144'hA || ir[1] !== 1'b0) begin
      $display("FAIL skid_b_full got d=%0h r=%b want d=a r=0", od[1], ir[1]); n_err++;
    end
    n_cmp++;
    ic[1] = 6'h0C; idat[1] = 144'hC;
    cyc();
    if (ov[1] !== 1'b1 || od[1] !== 144'hA || oc[1] !== 6'h0A || ir[1] !== 1'b0) begin
      $display("FAIL skid_hold got v=%b d=%0h c=%h r=%b want v=1 d=a c=0a r=0", ov[1], od[1], oc[1], ir[1]); n_err++;
    end
    n_cmp++;
    ordy[1] = 1'b1; iv[1] = 1'b0;
    cyc();
    if (ov[1] !== 1'b1 || od[1] !== 144'hB || ir[1] !== 1'b1) begin
      $display("FAIL skid_b_main got v=%b d=%0h r=%b want v=1 d=b r=1", ov[1], od[1], ir[1]); n_err++;
    end
    n_cmp++;
    cyc();
    if (ov[1] !== 1'b0 || oc[1] !== 6'h0) begin
      $display("FAIL skid_empty got v=%b c=%h want v=0 c=00", ov[1], oc[1]); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_stall_single();
    do_reset();
    ordy[0] = 1'b0; iv[0] = 1'b1; ic[0] = 6'h0A; idat[0] = 144'hA;
    cyc();
    if (ov[0] !== 1'b1 || od[0] !== 144'hA || ir[0] !== 1'b0) begin
      $display("FAIL single_stall got v=%b d=%0h r=%b want v=1 d=a r=0", ov[0], od[0], ir[0]); n_err++;
    end
    n_cmp++;
    ic[0] = 6'h0B; idat[0] = 144'hB;
    cyc();
    if (ov[0] !== 1'b1 || od[0] !== 144'hA) begin
      $display("FAIL single_hold got v=%b d=%0h want v=1 d=a", ov[0], od[0]); n_err++;
    end
    n_cmp++;
    iv[0] = 1'b0; ordy[0] = 1'b1;
    #1;
    if (ir[0] !== 1'b1) begin $display("FAIL single_ready got %b want 1", ir[0]); n_err++; end
    n_cmp++;
    cyc();
    if (ov[0] !== 1'b0) begin $display("FAIL single_drain got %b want 0", ov[0]); n_err++; end
    n_cmp++;
  endtask

  task automatic test_flush(input int d);
    do_reset();
    ordy[d] = 1'b0; iv[d] = 1'b1; ic[d] = 6'h3F; idat[d] = 144'hA;
    cyc();
    if (ov[d] !== 1'b1 || oc[d] !== 6'h3F) begin
      $display("FAIL flush_pre dut%0d got v=%b c=%h want v=1 c=3f", d, ov[d], oc[d]); n_err++;
    end
    n_cmp++;
    if (d == 1) begin
      idat[d] = 144'hB;
      cyc();
    end
    // A drains and C is accepted in the flush cycle; C must be squashed
    ordy[d] = 1'b1; flush[d] = 1'b1; ic[d] = 6'h21; idat[d] = 144'hC;
    cyc();
    flush[d] = 1'b0; iv[d] = 1'b0;
    if (ov[d] !== 1'b0 || oc[d] !== 6'h0 || ir[d] !== 1'b1) begin
      $display("FAIL flush_post dut%0d got v=%b c=%h r=%b want v=0 c=00 r=1", d, ov[d], oc[d], ir[d]); n_err++;
    end
    n_cmp++;
    cyc();
    if (ov[d] !== 1'b0) begin $display("FAIL flush_no_c dut%0d got v=%b d=%0h want v=0", d, ov[d], od[d]); n_err++; end
    n_cmp++;
  endtask

  task automatic test_bubbles();
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    if (bc[0] !== 16'd5) begin $display("FAIL bubble_count got %0d want 5", bc[0]); n_err++; end
    n_cmp++;
    if (bc[1] !== 16'd5) begin $display("FAIL bubble_count_skid got %0d want 5", bc[1]); n_err++; end
    n_cmp++;
    if (bc[2] !== 16'd3) begin $display("FAIL bubble_saturate got %0d want 3", bc[2]); n_err++; end
    n_cmp++;
    flush[0] = 1'b1;
    cyc();
    flush[0] = 1'b0; ordy[0] = 1'b0;
    cyc();
    if (bc[0] !== 16'd6) begin $display("FAIL bubble_flush got %0d want 6", bc[0]); n_err++; end
    n_cmp++;
    ordy[0] = 1'b1;
  endtask

  task automatic test_random(input int d, input int cycles);
    int unsigned q[$];
    int unsigned cnt = 1;
    logic exp_r;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      iv[d]    = ($urandom % 4) != 0;
      ordy[d]  = ($urandom % 3) != 0;
      flush[d] = ($urandom % 32) == 0;
      ic[d]    = 6'(cnt) | 6'h01;
      idat[d]  = 144'(cnt);
      #1;
      exp_r = (d == 0) ? (ordy[d] || q.size() == 0) : (q.size() < 2);
      if (ov[d] !== (q.size() != 0)) begin
        $display("FAIL rand_valid dut%0d cyc%0d got %b want %b", d, i, ov[d], q.size() != 0); n_err++;
      end
      n_cmp++;
      if (ir[d] !== exp_r) begin
        $display("FAIL rand_ready dut%0d cyc%0d got %b want %b", d, i, ir[d], exp_r); n_err++;
      end
      n_cmp++;
      if (q.size() != 0) begin
        if (od[d] !== 144'(q[0]) || oc[d] !== (6'(q[0]) | 6'h01)) begin
          $display("FAIL rand_beat dut%0d cyc%0d got d=%0h c=%h want d=%0h c=%h",
                   d, i, od[d], oc[d], q[0], 6'(q[0]) | 6'h01); n_err++;
        end
        n_cmp++;
        if (ordy[d]) void'(q.pop_front());
      end else begin
        if (oc[d] !== 6'h0) begin $display("FAIL rand_nop dut%0d cyc%0d got %h want 00", d, i, oc[d]); n_err++; end
        n_cmp++;
      end
      if (flush[d]) q.delete();
      else if (iv[d] && exp_r) q.push_back(cnt);
      if (iv[d]) cnt++;
      @(posedge clk);
      #1;
    end
    iv[d] = 1'b0; flush[d] = 1'b0; ordy[d] = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = '0; iv = '0; ordy = '0;
    for (int d = 0; d < 3; d++) begin ic[d] = '0; idat[d] = '0; end
    cyc();
    test_reset();
    test_stream(0);
    test_stream(1);
    test_stall_single();
    test_stall_skid();
    test_flush(0);
    test_flush(1);
    test_bubbles();
    test_random(0, 3000);
    test_random(1, 3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
